// File: rtl/i2c_xfer_seq_if.sv
// Host command and master-block register bus seen by the I2C transaction sequencer.
interface i2c_xfer_seq_if;
    logic       i_start;
    logic [6:0] i_dev_addr;
    logic [7:0] i_reg_addr;
    logic       i_rnw;
    logic [3:0] i_len;
    logic [7:0] i_wdata;
    logic       o_wdata_req;
    logic [7:0] o_rdata;
    logic       o_rdata_vld;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_err_code;
    logic       o_wr_ena;
    logic [4:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_rd_ena;
    logic [4:0] o_rd_addr;
    logic [7:0] i_rd_data;

    modport master (
        input  i_start, i_dev_addr, i_reg_addr, i_rnw, i_len, i_wdata, i_rd_data,
        output o_wdata_req, o_rdata, o_rdata_vld, o_busy, o_done, o_err,
        output o_err_code, o_wr_ena, o_wr_addr, o_wr_data, o_rd_ena, o_rd_addr
    );

    modport slave (
        output i_start, i_dev_addr, i_reg_addr, i_rnw, i_len, i_wdata, i_rd_data,
        input  o_wdata_req, o_rdata, o_rdata_vld, o_busy, o_done, o_err,
        input  o_err_code, o_wr_ena, o_wr_addr, o_wr_data, o_rd_ena, o_rd_addr
    );
endinterface

// File: rtl/i2c_xfer_seq.sv
// I2C register-access sequencer: drives the master block's register port
// through START, address, data, ACK polling and STOP for one host command.
module i2c_xfer_seq #(
    parameter logic [7:0] FDR_INIT = 8'h00,
    parameter int         POLL_GAP = 16,
    parameter int         TIMEOUT  = 4096
) (
    input logic     i_sysclk,
    input logic     i_reset,
    i2c_xfer_seq_if.master bus
);
    localparam int PW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    localparam logic [4:0] A_FDR = 5'h04;
    localparam logic [4:0] A_CR  = 5'h08;
    localparam logic [4:0] A_SR  = 5'h0C;
    localparam logic [4:0] A_DR  = 5'h10;

    typedef enum logic [4:0] {
        S_IDLE, S_INIT, S_START, S_DEVW, S_REG, S_WDATA, S_RSTART,
        S_DEVR, S_RSETUP, S_RDATA, S_STOP, S_WAITIDLE, S_ABORT, S_DONE,
        S_WRG, S_RD1, S_RD2, S_POLL, S_PCHK, S_PGAP
    } state_t;

    state_t        state_q, state_d, ret_q, ret_d;
    logic [2:0]    step_q, step_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic          rnw_q, rnw_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    sr_q, sr_d;
    logic          poll_q, poll_d;
    logic          emit_q, emit_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    wbit_q, wbit_d;
    logic          wval_q, wval_d;

    logic          wr_ena_q, wr_ena_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rd_ena_q, rd_ena_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          vld_q, vld_d;
    logic          wreq_q, wreq_d;

    logic          do_wr, do_rd, do_wait, go, w_val;
    logic [4:0]    wr_a, rd_a;
    logic [7:0]    wr_v, tx_byte;
    logic [2:0]    w_bit;
    state_t        go_s, ack_next;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        step_d    = step_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        rnw_d     = rnw_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        sr_d      = sr_q;
        poll_d    = poll_q;
        emit_d    = emit_q;
        pcnt_d    = pcnt_q;
        gap_d     = gap_q;
        wbit_d    = wbit_q;
        wval_d    = wval_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_ena_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        rdata_d   = rdata_q;
        vld_d     = 1'b0;
        wreq_d    = 1'b0;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        do_wait   = 1'b0;
        go        = 1'b0;
        go_s      = S_IDLE;
        wr_a      = A_CR;
        wr_v      = 8'h80;
        rd_a      = A_DR;
        w_bit     = 3'd1;
        w_val     = 1'b1;
        tx_byte   = {dev_q, 1'b0};
        ack_next  = S_REG;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.i_start && !busy_q) begin
                    dev_d  = bus.i_dev_addr;
                    reg_d  = bus.i_reg_addr;
                    rnw_d  = bus.i_rnw;
                    cnt_d  = (bus.i_rnw && bus.i_len == 4'd0) ? 4'd1 : bus.i_len;
                    code_d = 2'd0;
                    busy_d = 1'b1;
                    go     = 1'b1;
                    go_s   = S_INIT;
                end
            end
            S_INIT: begin
                case (step_q)
                    3'd0:    begin do_wr = 1'b1; wr_a = A_FDR; wr_v = FDR_INIT; end
                    3'd1:    do_wr = 1'b1;
                    default: begin go = 1'b1; go_s = S_START; end
                endcase
            end
            S_START: begin
                case (step_q)
                    3'd0:    begin do_wr = 1'b1; wr_v = 8'hB0; end
                    3'd1:    begin do_wait = 1'b1; w_bit = 3'd5; end
                    default: begin go = 1'b1; go_s = S_DEVW; end
                endcase
            end
            S_DEVW, S_REG, S_DEVR: begin
                if (state_q == S_REG) begin
                    tx_byte  = reg_q;
                    ack_next = rnw_q ? S_RSTART :
                               (cnt_q == 4'd0) ? S_STOP : S_WDATA;
                end else if (state_q == S_DEVR) begin
                    tx_byte  = {dev_q, 1'b1};
                    ack_next = S_RSETUP;
                end
                case (step_q)
                    3'd0:    begin do_wr = 1'b1; wr_a = A_DR; wr_v = tx_byte; end
                    3'd1:    do_wait = 1'b1;
                    3'd2:    begin do_wr = 1'b1; wr_a = A_SR; wr_v = 8'h00; end
                    default: begin
                        go = 1'b1;
                        if (sr_q[0]) begin
                            code_d = 2'd1;
                            go_s   = S_ABORT;
                        end else begin
                            go_s   = ack_next;
                        end
                    end
                endcase
            end
            S_WDATA: begin
                case (step_q)
                    3'd0:    begin wreq_d = 1'b1; step_d = 3'd1; end
                    3'd1:    begin do_wr = 1'b1; wr_a = A_DR; wr_v = bus.i_wdata; end
                    3'd2:    do_wait = 1'b1;
                    3'd3:    begin do_wr = 1'b1; wr_a = A_SR; wr_v = 8'h00; end
                    default: begin
                        if (sr_q[0]) begin
                            code_d = 2'd1;
                            go     = 1'b1;
                            go_s   = S_ABORT;
                        end else if (cnt_q == 4'd1) begin
                            go     = 1'b1;
                            go_s   = S_STOP;
                        end else begin
                            cnt_d  = cnt_q - 4'd1;
                            step_d = 3'd0;
                        end
                    end
                endcase
            end
            S_RSTART: begin
                case (step_q)
                    3'd0:    begin do_wr = 1'b1; wr_v = 8'hB4; end
                    default: begin go = 1'b1; go_s = S_DEVR; end
                endcase
            end
            S_RSETUP: begin
                case (step_q)
                    3'd0: begin
                        do_wr = 1'b1;
                        wr_v  = (cnt_q == 4'd1) ? 8'hA8 : 8'hA0;
                    end
                    3'd1:    begin do_rd = 1'b1; emit_d = 1'b0; end
                    default: begin k_d = 4'd1; go = 1'b1; go_s = S_RDATA; end
                endcase
            end
            S_RDATA: begin
                case (step_q)
                    3'd0: do_wait = 1'b1;
                    3'd1: begin do_wr = 1'b1; wr_a = A_SR; wr_v = 8'h00; end
                    3'd2: begin
                        // NAK setup goes out one byte early so the last byte is not ACKed
                        if (k_q == cnt_q) begin
                            do_wr = 1'b1;
                        end else if (k_q == cnt_q - 4'd1) begin
                            do_wr = 1'b1;
                            wr_v  = 8'hA8;
                        end else begin
                            step_d = 3'd3;
                        end
                    end
                    3'd3: begin do_rd = 1'b1; emit_d = 1'b1; end
                    default: begin
                        emit_d = 1'b0;
                        if (k_q == cnt_q) begin
                            go   = 1'b1;
                            go_s = S_WAITIDLE;
                        end else begin
                            k_d    = k_q + 4'd1;
                            step_d = 3'd0;
                        end
                    end
                endcase
            end
            S_STOP: begin
                case (step_q)
                    3'd0:    do_wr = 1'b1;
                    default: begin go = 1'b1; go_s = S_WAITIDLE; end
                endcase
            end
            S_WAITIDLE: begin
                case (step_q)
                    3'd0:    begin do_wait = 1'b1; w_bit = 3'd5; w_val = 1'b0; end
                    default: begin go = 1'b1; go_s = S_DONE; end
                endcase
            end
            S_ABORT: begin
                case (step_q)
                    3'd0:    do_wr = 1'b1;
                    default: begin go = 1'b1; go_s = S_DONE; end
                endcase
            end
            S_DONE: begin
                done_d  = 1'b1;
                err_d   = (code_q != 2'd0);
                state_d = S_IDLE;
            end
            S_WRG: state_d = ret_q;
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                if (poll_q) begin
                    sr_d    = bus.i_rd_data;
                    state_d = S_PCHK;
                    if (pcnt_q != PW'(TIMEOUT))
                        pcnt_d = pcnt_q + 1'b1;
                end else begin
                    state_d = ret_q;
                    if (emit_q) begin
                        rdata_d = bus.i_rd_data;
                        vld_d   = 1'b1;
                    end
                end
            end
            S_POLL: begin
                rd_ena_d  = 1'b1;
                rd_addr_d = A_SR;
                state_d   = S_RD1;
            end
            S_PCHK: begin
                if (sr_q[4]) begin
                    code_d  = 2'd2;
                    poll_d  = 1'b0;
                    step_d  = 3'd0;
                    state_d = S_ABORT;
                end else if (sr_q[wbit_q] == wval_q) begin
                    poll_d  = 1'b0;
                    state_d = ret_q;
                end else if (pcnt_q == PW'(TIMEOUT)) begin
                    code_d  = 2'd3;
                    poll_d  = 1'b0;
                    step_d  = 3'd0;
                    state_d = (ret_q == S_WAITIDLE) ? S_DONE : S_ABORT;
                end else begin
                    gap_d   = '0;
                    state_d = S_PGAP;
                end
            end
            S_PGAP: begin
                if (gap_q == GW'(POLL_GAP - 1))
                    state_d = S_POLL;
                else
                    gap_d = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_wr) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = wr_a;
            wr_data_d = wr_v;
            state_d   = S_WRG;
            ret_d     = state_q;
            step_d    = step_q + 3'd1;
        end
        if (do_rd) begin
            rd_ena_d  = 1'b1;
            rd_addr_d = rd_a;
            state_d   = S_RD1;
            ret_d     = state_q;
            step_d    = step_q + 3'd1;
        end
        if (do_wait) begin
            poll_d  = 1'b1;
            pcnt_d  = '0;
            wbit_d  = w_bit;
            wval_d  = w_val;
            state_d = S_POLL;
            ret_d   = state_q;
            step_d  = step_q + 3'd1;
        end
        if (go) begin
            state_d = go_s;
            step_d  = 3'd0;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            step_q    <= '0;
            dev_q     <= '0;
            reg_q     <= '0;
            rnw_q     <= 1'b0;
            cnt_q     <= '0;
            k_q       <= '0;
            sr_q      <= '0;
            poll_q    <= 1'b0;
            emit_q    <= 1'b0;
            pcnt_q    <= '0;
            gap_q     <= '0;
            wbit_q    <= '0;
            wval_q    <= 1'b0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_ena_q  <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            rdata_q   <= '0;
            vld_q     <= 1'b0;
            wreq_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            step_q    <= step_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            rnw_q     <= rnw_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            sr_q      <= sr_d;
            poll_q    <= poll_d;
            emit_q    <= emit_d;
            pcnt_q    <= pcnt_d;
            gap_q     <= gap_d;
            wbit_q    <= wbit_d;
            wval_q    <= wval_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_ena_q  <= rd_ena_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            rdata_q   <= rdata_d;
            vld_q     <= vld_d;
            wreq_q    <= wreq_d;
        end
    end

    assign bus.o_wr_ena    = wr_ena_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_rd_ena    = rd_ena_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_code  = code_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_rdata_vld = vld_q;
    assign bus.o_wdata_req = wreq_q;
endmodule

// File: doc/i2c_xfer_seq.md
# i2c_xfer_seq

Transaction sequencer that sits directly upstream of the I2C master register block. It accepts one host command: device address, register address, direction and length. It then drives the block's register write/read strobes to perform a complete I2C register access: START, address phases, repeated START for reads, data bytes with ACK/NAK handling, and STOP. Firmware no longer needs to poll MIF/MCF itself; the sequencer does it in hardware and reports done/error.

## Interface
- FDR_INIT, 8'h00: value written to FDR at each transaction start.
- POLL_GAP, 16: idle cycles between consecutive SR polls (min 2).
- TIMEOUT, 4096: SR polls without the awaited condition before abort.
- i_sysclk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle command pulse; ignored while o_busy=1.
- i_dev_addr  in  7  7-bit target address.
- i_reg_addr  in  8  target register index, sent after device address.
- i_rnw  in  1  1=read, 0=write.
- i_len  in  4  data byte count 0..15 (read with 0 treated as 1).
- i_wdata  in  8  write byte, sampled when o_wdata_req=1.
- o_wdata_req  out  1  one-cycle request; i_wdata must be valid same cycle.
- o_rdata  out  8  received byte.
- o_rdata_vld  out  1  one-cycle strobe with o_rdata.
- o_busy, o_done, o_err  out  1 each  busy level; done pulse; error pulse (coincident with o_done).
- o_err_code  out  2  0 none, 1 NAK, 2 arbitration lost, 3 timeout; held until next i_start.
- o_wr_ena, o_wr_addr[4:0], o_wr_data[7:0]  out  register write port to the master block.
- o_rd_ena, o_rd_addr[4:0]  out  register read port; i_rd_data[7:0] in.

## Operation
- Register offsets (o_*_addr): ADR 0x00, FDR 0x04, CR 0x08, SR 0x0C, DR 0x10, DFSRR 0x14.
- CR bits: MEN 7, MIEN 6, MSTA 5, MTX 4, TXAK 3, RSTA 2.
- SR bits: MCF 7, MBB 5, MAL 4, MIF 1, RXAK 0.
- Register access primitive: one-cycle strobe on o_wr_ena or o_rd_ena. Each strobe is followed by at least one low cycle, because the master block is edge-sensitive. For reads, i_rd_data is sampled 2 cycles after the strobe.
- WAIT(cond): read SR, then wait POLL_GAP cycles.
  - If MAL=1: abort with code 2.
  - If cond is not met, repeat. After TIMEOUT polls without cond: abort with code 3.
- ACKCHK (after each transmitted byte): WAIT(MIF=1), then write SR=0x00 to clear MIF. If RXAK=1: abort with code 1.
- States:
  - IDLE: on i_start, latch the command, clear o_err_code, go to INIT.
  - INIT: write FDR=FDR_INIT, then CR=0x80.
  - START: write CR=0xB0; WAIT(MBB=1).
  - DEVW: write DR={dev,0}; ACKCHK.
  - REG: write DR=reg; ACKCHK. Next state is WDATA if write, RSTART if read.
  - WDATA, repeated i_len times: pulse o_wdata_req, write DR=i_wdata; ACKCHK. Then go to STOP.
  - RSTART: write CR=0xB4.
  - DEVR: write DR={dev,1}; ACKCHK.
  - RSETUP: write CR = 0xA0, or 0xA8 if N=1. Then dummy-read DR, discarding the data.
  - RDATA, for k=1..N:
    - WAIT(MIF=1), then write SR=0x00.
    - If k=N, write CR=0x80 (this generates the STOP); if k=N-1, write CR=0xA8.
    - Read DR and emit o_rdata/o_rdata_vld.
    - After k=N, go to WAITIDLE.
  - STOP: write CR=0x80.
  - WAITIDLE: WAIT(MBB=0), then DONE.
  - DONE: pulse o_done (and o_err if the code is non-zero), then IDLE.
  - ABORT: write CR=0x80, then DONE. A timeout during WAITIDLE goes directly to DONE.
- i_start while busy: ignored, no effect on the transaction in progress.

## Timing
- Reset values:
  - o_wr_ena=0, o_rd_ena=0; o_wr_addr=0, o_rd_addr=0, o_wr_data=0.
  - o_busy=0, o_done=0, o_err=0, o_err_code=0.
  - o_rdata=0, o_rdata_vld=0, o_wdata_req=0; state IDLE.
- o_busy rises the cycle after i_start and falls the cycle after o_done.
- The first o_wr_ena (FDR) is asserted 1 cycle after o_busy rises.
- o_wdata_req precedes the matching DR write strobe by 1 cycle.
- o_rdata_vld is asserted 2 cycles after the DR read strobe.
- Write strobe and read strobe are never asserted in the same cycle.
- Poll counter width is clog2(TIMEOUT+1) and saturates; it resets at each new WAIT.
- Reset mid-transaction: all outputs return to reset values next cycle. No STOP is issued; the master block is reset by its own reset.

## Test plan
- Write, dev 0x50, reg 0x10, len 2, data 0x11/0x22, behavioural master returning MIF=1/RXAK=0:
  - Write sequence: FDR=00, CR=80, CR=B0, DR=A0, DR=10, DR=11, DR=22, CR=80.
  - Two o_wdata_req pulses; o_done=1, o_err=0.
- Read, dev 0x50, reg 0x3C, len 1, model DR returns 0x5A:
  - CR writes in order: 80, B0, B4, A8, 80; DR writes A0, 3C, A1.
  - One o_rdata_vld with 0x5A; the CR=80 write precedes the final DR read.
- Read len 3:
  - CR=A0 is written at setup; CR=A8 after byte 2's MIF; CR=80 after byte 3's MIF.
  - Exactly 3 o_rdata_vld.
- NAK: SR reads RXAK=1 after DEVW → CR=80 written, o_err=1, o_err_code=1, no REG write.
- Timeout: MIF held 0 with TIMEOUT=8 → exactly 8 SR polls, then o_err_code=3. Arbitration lost: MAL=1 on the first poll → code 2.
- Reset mid-operation: i_reset during WDATA → next cycle all outputs at reset values. A new i_start then completes normally. i_start while busy is ignored.
